// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte sources, the UART TX core and uart_tx_arbiter.
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   grant                                 : one-hot current owner, 0 when idle
//   tx_data/tx_start/tx_busy              : UART TX core start/busy interface
//   timeout_pulse                         : one-cycle pulse on forced lock release
// Modports: slave = the arbiter, master = requesters plus UART core side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              timeout_pulse;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_data, tx_start, timeout_pulse
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_data, tx_start, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte sources. Round-robin grant with
// packet locking: the owner keeps the UART until its byte flagged last has been
// sent. A stalled owner loses the lock after TIMEOUT idle cycles in ACCEPT.
// Ports:
//   clk12   : system clock (12 MHz)
//   resetn  : synchronous reset, active low
//   bus     : uart_tx_arbiter_if.slave (request handshake, grant, UART start/busy,
//             timeout pulse)
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no owner; pick next valid requester starting at rr_ptr
// S_ACCEPT   | owner granted; ready while UART idle; timeout counter running
// S_WAIT_BUSY| tx_start issued; wait up to BUSY_WAIT cycles for tx_busy
// S_WAIT_DONE| UART shifting; on tx_busy low release lock or take next byte
module uart_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 1200,
    parameter int BUSY_WAIT = 4
) (
    input logic               clk12,
    input logic               resetn,
    uart_tx_arbiter_if.slave  bus
);
    localparam int RW = (NREQ > 1)      ? $clog2(NREQ)      : 1;
    localparam int TW = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;
    localparam int BW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            state;
    logic [NREQ-1:0]   grant_q;
    logic [RW-1:0]     owner_idx;
    logic [RW-1:0]     rr_ptr;
    logic [TW-1:0]     to_cnt;
    logic [BW-1:0]     bw_cnt;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              timeout_pulse_q;
    logic              last_q;

    logic [NREQ-1:0]   pick_oh;
    logic [RW-1:0]     pick_idx;
    logic              pick_found;
    logic [7:0]        sel_data;
    logic              sel_last;
    logic [NREQ-1:0]   ready;
    logic              handshake;
    logic              byte_done;
    logic [RW-1:0]     next_ptr;

    // Rotating priority: first pass covers rr_ptr..NREQ-1, second pass wraps to 0.
    always_comb begin
        pick_oh    = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && bus.req_valid[i] && (RW'(i) >= rr_ptr)) begin
                pick_found  = 1'b1;
                pick_idx    = RW'(i);
                pick_oh[i]  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && bus.req_valid[i]) begin
                pick_found  = 1'b1;
                pick_idx    = RW'(i);
                pick_oh[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sel_data = bus.req_data[8*i +: 8];
                sel_last = bus.req_last[i];
            end
        end
    end

    assign ready     = (state == S_ACCEPT && !bus.tx_busy) ? grant_q : '0;
    assign handshake = |(bus.req_valid & ready);

    // A byte is finished when the UART drops busy, or when it never raised busy
    // within the BUSY_WAIT window (dead or absent core).
    assign byte_done = !bus.tx_busy &&
                       ((state == S_WAIT_DONE) ||
                        (state == S_WAIT_BUSY && bw_cnt == BW'(BUSY_WAIT - 1)));

    assign next_ptr  = (owner_idx == RW'(NREQ - 1)) ? '0 : owner_idx + RW'(1);

    always_ff @(posedge clk12) begin
        if (!resetn) begin
            state           <= S_IDLE;
            grant_q         <= '0;
            owner_idx       <= '0;
            rr_ptr          <= '0;
            to_cnt          <= '0;
            bw_cnt          <= '0;
            tx_data_q       <= '0;
            tx_start_q      <= 1'b0;
            timeout_pulse_q <= 1'b0;
            last_q          <= 1'b0;
        end else begin
            tx_start_q      <= 1'b0;
            timeout_pulse_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q   <= pick_oh;
                        owner_idx <= pick_idx;
                        to_cnt    <= '0;
                        state     <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (handshake) begin
                        tx_data_q  <= sel_data;
                        last_q     <= sel_last;
                        tx_start_q <= 1'b1;
                        bw_cnt     <= '0;
                        state      <= S_WAIT_BUSY;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        grant_q         <= '0;
                        timeout_pulse_q <= 1'b1;
                        rr_ptr          <= next_ptr;
                        state           <= S_IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (byte_done) begin
                        if (last_q) begin
                            grant_q <= '0;
                            rr_ptr  <= next_ptr;
                            state   <= S_IDLE;
                        end else begin
                            to_cnt  <= '0;
                            state   <= S_ACCEPT;
                        end
                    end else if (state == S_WAIT_BUSY) begin
                        if (bus.tx_busy) begin
                            state <= S_WAIT_DONE;
                        end else begin
                            bw_cnt <= bw_cnt + BW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = ready;
    assign bus.grant         = grant_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_start      = tx_start_q;
    assign bus.timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet rounds
// checked against a packet-level round-robin model of the expected UART stream.
module tb_uart_tx_arbiter;
    localparam int NREQ      = 2;
    localparam int TIMEOUT   = 16;
    localparam int BUSY_WAIT = 4;

    logic clk12  = 1'b0;
    logic resetn = 1'b0;
    always #5 clk12 = ~clk12;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ      (NREQ),
        .TIMEOUT   (TIMEOUT),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk12  (clk12),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string tag, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // requester byte queues, entry = {last, data}
    logic [8:0] rq [NREQ][$];

    int  cyc        = 0;
    int  busy_left  = 0;
    int  busy_len   = 10;
    bit  uart_dead  = 1'b0;
    bit  busy_force = 1'b0;
    int  n_to       = 0;
    int  model_ptr  = 0;

    logic [NREQ-1:0] s_grant, s_ready, s_hs;
    logic [7:0]      s_data;
    logic            s_start, s_to, s_busy;
    int              s_cyc;

    int obs_d[$], obs_g[$], obs_c[$], hs_c[$];
    int exp_d[$], exp_g[$];

    function automatic int oh_idx(logic [NREQ-1:0] g);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                r = i;
                n++;
            end
        end
        if (n != 1) r = -1;
        return r;
    endfunction

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                e = rq[i][0];
                bus.req_valid[i]         = 1'b1;
                bus.req_data[8*i +: 8]   = e[7:0];
                bus.req_last[i]          = e[8];
            end else begin
                bus.req_valid[i]         = 1'b0;
                bus.req_data[8*i +: 8]   = 8'h00;
                bus.req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic push_byte(int r, logic [7:0] d, bit last);
        rq[r].push_back({last, d});
    endtask

    // One clock: sample at negedge, then update requesters and UART model after posedge.
    task automatic step();
        bit start_seen;
        @(negedge clk12);
        s_cyc   = cyc;
        s_grant = bus.grant;
        s_ready = bus.req_ready;
        s_hs    = bus.req_valid & bus.req_ready;
        s_data  = bus.tx_data;
        s_start = bus.tx_start;
        s_to    = bus.timeout_pulse;
        s_busy  = bus.tx_busy;
        if (s_start) begin
            obs_d.push_back(int'(s_data));
            obs_g.push_back(oh_idx(s_grant));
            obs_c.push_back(s_cyc);
        end
        if (s_hs != '0) hs_c.push_back(s_cyc);
        if (s_to) n_to++;
        start_seen = s_start;
        @(posedge clk12);
        #1;
        cyc++;
        if (resetn) begin
            for (int i = 0; i < NREQ; i++)
                if (s_hs[i]) void'(rq[i].pop_front());
        end
        if (busy_force) begin
            bus.tx_busy = 1'b1;
        end else begin
            if (start_seen && !uart_dead) busy_left = busy_len;
            if (busy_left > 0) begin
                bus.tx_busy = 1'b1;
                busy_left--;
            end else begin
                bus.tx_busy = 1'b0;
            end
        end
        drive();
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (rq[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_idle(string tag, int budget);
        int k    = 0;
        bit done = 1'b0;
        while (!done && k < budget) begin
            step();
            k++;
            done = queues_empty() && (s_grant == '0) && (busy_left == 0) && !s_busy && !s_start;
        end
        chk({tag, "_idle"}, int'(done), 1);
    endtask

    // Packet-level round robin: each packet goes out whole; the next owner is the
    // first requester with pending bytes searching from the previous owner + 1.
    task automatic build_expect();
        logic [8:0] mq [NREQ][$];
        logic [8:0] e;
        int g;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        for (int guard = 0; guard < 1000; guard++) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (model_ptr + k) % NREQ;
                if (g < 0 && mq[j].size() > 0) g = j;
            end
            if (g < 0) break;
            do begin
                e = mq[g].pop_front();
                exp_d.push_back(int'(e[7:0]));
                exp_g.push_back(g);
            end while (!e[8] && mq[g].size() > 0);
            model_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic compare_stream(string tag);
        chk({tag, "_count"}, obs_d.size(), exp_d.size());
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            chk($sformatf("%s_data%0d", tag, k), obs_d[k], exp_d[k]);
            chk($sformatf("%s_owner%0d", tag, k), obs_g[k], exp_g[k]);
        end
        obs_d.delete(); obs_g.delete(); obs_c.delete(); hs_c.delete();
        exp_d.delete(); exp_g.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, toc, to0, viol, npk, len, r;
        logic [NREQ-1:0] g_at_to;
        bit seen;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;

        // reset state
        resetn = 1'b0;
        repeat (3) step();
        chk("rst_grant", int'(s_grant), 0);
        chk("rst_tx_data", int'(s_data), 0);
        chk("rst_tx_start", int'(s_start), 0);
        chk("rst_timeout", int'(s_to), 0);
        chk("rst_ready", int'(s_ready), 0);
        resetn = 1'b1;
        step();

        // 1: single byte, start one cycle after handshake
        push_byte(0, 8'h41, 1'b1);
        drive();
        build_expect();
        run_idle("t1", 100);
        if (obs_c.size() > 0 && hs_c.size() > 0)
            chk("t1_latency", obs_c[0] - hs_c[0], 1);
        compare_stream("t1");

        // 2: contention, req1 favoured after req0 was served
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h0A, 1'b1);
        push_byte(1, 8'h78, 1'b0); push_byte(1, 8'h79, 1'b0); push_byte(1, 8'h0A, 1'b1);
        drive();
        build_expect();
        run_idle("t2", 300);
        if (obs_g.size() > 0) chk("t2_first_owner", obs_g[0], 1);
        compare_stream("t2");

        // 3: owner stalls mid-packet, lock force-released after TIMEOUT cycles
        push_byte(1, 8'h55, 1'b0);
        drive();
        step();
        push_byte(0, 8'h33, 1'b1);
        drive();
        acc = -1; toc = -1; seen = 1'b0; viol = 0; to0 = n_to; g_at_to = '1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (s_start && s_data == 8'h55) seen = 1'b1;
            if (seen && acc < 0 && s_ready[1]) acc = s_cyc;
            if (s_to && toc < 0) begin
                toc     = s_cyc;
                g_at_to = s_grant;
            end
            if (s_grant[1] && s_ready[0]) viol++;
            if (toc >= 0 && queues_empty() && s_grant == '0 && busy_left == 0 && !s_busy) break;
        end
        chk("t3_to_delay", toc - acc, TIMEOUT);
        chk("t3_to_count", n_to - to0, 1);
        chk("t3_grant_at_to", int'(g_at_to), 0);
        chk("t3_lock", viol, 0);
        exp_d.push_back(8'h55); exp_g.push_back(1);
        exp_d.push_back(8'h33); exp_g.push_back(0);
        model_ptr = 1;
        compare_stream("t3");

        // 4: dead UART, each byte bounded by BUSY_WAIT
        uart_dead = 1'b1;
        push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b0); push_byte(0, 8'h03, 1'b1);
        drive();
        build_expect();
        run_idle("t4", 200);
        if (obs_c.size() >= 3) begin
            chk("t4_gap1", obs_c[1] - obs_c[0], BUSY_WAIT + 1);
            chk("t4_gap2", obs_c[2] - obs_c[1], BUSY_WAIT + 1);
        end
        compare_stream("t4");
        uart_dead = 1'b0;

        // 5: reset mid-packet while UART busy
        push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b1);
        drive();
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_start) break;
        end
        repeat (3) step();
        resetn = 1'b0;
        step();
        step();
        chk("t5_grant", int'(s_grant), 0);
        chk("t5_tx_start", int'(s_start), 0);
        chk("t5_tx_data", int'(s_data), 0);
        chk("t5_busy_during_rst", int'(s_busy), 1);
        resetn = 1'b1;
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (s_busy && (s_ready != '0 || s_start)) viol++;
            if (queues_empty() && s_grant == '0 && busy_left == 0 && !s_busy) break;
        end
        chk("t5_wait_busy", viol, 0);
        exp_d.push_back(8'h11); exp_g.push_back(0);
        exp_d.push_back(8'h22); exp_g.push_back(0);
        model_ptr = 1;
        compare_stream("t5");

        // 6: backpressure from tx_busy in ACCEPT
        busy_force = 1'b1;
        step();
        push_byte(0, 8'h66, 1'b1);
        drive();
        viol = 0;
        repeat (6) begin
            step();
            if (s_ready != '0 || s_start) viol++;
        end
        chk("t6_blocked", viol, 0);
        chk("t6_grant", int'(s_grant), 1);
        busy_force  = 1'b0;
        bus.tx_busy = 1'b0;
        step();
        chk("t6_ready", int'(s_ready), 1);
        chk("t6_hs", int'(s_hs), 1);
        step();
        chk("t6_start", int'(s_start), 1);
        run_idle("t6", 100);
        exp_d.push_back(8'h66); exp_g.push_back(0);
        model_ptr = 1;
        compare_stream("t6");

        // randomized packet rounds
        for (int rnd = 0; rnd < 40; rnd++) begin
            busy_len  = int'($urandom_range(1, 12));
            uart_dead = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NREQ; i++) begin
                npk = int'($urandom_range(0, 2));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++)
                        push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            if (queues_empty()) begin
                r = int'($urandom_range(0, NREQ - 1));
                push_byte(r, 8'($urandom_range(0, 255)), 1'b1);
            end
            drive();
            build_expect();
            run_idle($sformatf("rnd%0d", rnd), 3000);
            compare_stream($sformatf("rnd%0d", rnd));
        end
        uart_dead = 1'b0;

        chk("timeout_total", n_to, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
